// File: rtl/pps_cond_pkg.sv
// Shared types and widths for the PPS conditioner: FSM state encoding and counter sizes.
package pps_cond_pkg;

  localparam int CNT_W  = 32;
  localparam int ERR_W  = 8;
  localparam int GOOD_W = 2;
  localparam int MISS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } pps_state_e;

endpackage

// File: rtl/ed_det.sv
// Registered single-bit edge detector; TYPE selects "ris", "fal" or "both".
module ed_det #(
  parameter string TYPE = "ris"
) (
  input  logic clk,
  input  logic resetn,
  input  logic sig,
  output logic ed
);

  logic sig_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sig_d <= 1'b0;
      ed    <= 1'b0;
    end else begin
      sig_d <= sig;
      if (TYPE == "fal")
        ed <= ~sig & sig_d;
      else if (TYPE == "both")
        ed <= sig ^ sig_d;
      else
        ed <= sig & ~sig_d;
    end
  end

endmodule

// File: rtl/pps_conditioner.sv
// Qualifies an external PPS against the local clock, emitting one pulse per second and
// bridging short PPS outages with synthetic pulses while tracking lock state.
module pps_conditioner
  import pps_cond_pkg::*;
#(
  parameter int unsigned NOM_PERIOD = 100000000,
  parameter int unsigned TOL        = 1000,
  parameter int unsigned MISS_MAX   = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pps_in,
  input  logic             enable,
  output logic             sec_pulse_ed,
  output logic             synth,
  output logic             locked,
  output logic             holdover,
  output logic [CNT_W-1:0] period_fix,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0]  WIN_LO    = CNT_W'(NOM_PERIOD - TOL);
  localparam logic [CNT_W-1:0]  WIN_HI    = CNT_W'(NOM_PERIOD + TOL);
  localparam logic [CNT_W-1:0]  NOM       = CNT_W'(NOM_PERIOD);
  localparam logic [CNT_W-1:0]  HOLD_CNT0 = CNT_W'(TOL + 1);
  localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(MISS_MAX);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  logic       pps_p0, pps_p1;
  logic [3:0] arm_sr;
  logic       ed_raw, edge_hit;

  // Stage p0/p1: two-flop synchroniser; arm_sr masks edges until the whole
  // chain (including the detector's history flop) holds real samples, so a
  // PPS that is already high at reset release is not seen as a new edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pps_p0 <= 1'b0;
      pps_p1 <= 1'b0;
      arm_sr <= '0;
    end else begin
      pps_p0 <= pps_in;
      pps_p1 <= pps_p0;
      arm_sr <= {arm_sr[2:0], 1'b1};
    end
  end

  ed_det #(.TYPE("ris")) u_ed_det (
    .clk    (clk),
    .resetn (resetn),
    .sig    (pps_p1),
    .ed     (ed_raw)
  );

  assign edge_hit = ed_raw & arm_sr[3];

  pps_state_e        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [GOOD_W-1:0] good, good_nx;
  logic [MISS_W-1:0] miss, miss_nx, miss_inc;
  logic              emit, emit_syn, fix_ld, err_inc, in_win;

  assign in_win   = (cnt >= WIN_LO) && (cnt <= WIN_HI);
  assign miss_inc = miss + MISS_W'(1);

  always_comb begin
    state_nx = state;
    cnt_nx   = sat_inc_cnt(cnt);
    good_nx  = good;
    miss_nx  = miss;
    emit     = 1'b0;
    emit_syn = 1'b0;
    fix_ld   = 1'b0;
    err_inc  = 1'b0;
    if (!enable) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      good_nx  = '0;
      miss_nx  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_ACQUIRE;
          cnt_nx   = '0;
          good_nx  = '0;
          miss_nx  = '0;
        end
        ST_ACQUIRE: begin
          if (edge_hit) begin
            emit   = 1'b1;
            cnt_nx = CNT_W'(1);
            if (in_win) begin
              fix_ld  = 1'b1;
              good_nx = good + GOOD_W'(1);
              if (good_nx == GOOD_W'(2)) state_nx = ST_LOCKED;
            end else begin
              good_nx = '0;
            end
          end
        end
        ST_LOCKED: begin
          // A real edge takes priority over the timeout on the same cycle.
          if (edge_hit) begin
            if (in_win) begin
              emit   = 1'b1;
              fix_ld = 1'b1;
              cnt_nx = CNT_W'(1);
            end else begin
              err_inc = 1'b1;
            end
          end else if (cnt >= WIN_HI) begin
            emit     = 1'b1;
            emit_syn = 1'b1;
            miss_nx  = MISS_W'(1);
            cnt_nx   = HOLD_CNT0;
            state_nx = ST_HOLDOVER;
          end
        end
        ST_HOLDOVER: begin
          if (edge_hit) begin
            if ((cnt >= WIN_LO) && (cnt <= NOM)) begin
              emit     = 1'b1;
              cnt_nx   = CNT_W'(1);
              miss_nx  = '0;
              state_nx = ST_LOCKED;
            end else begin
              err_inc = 1'b1;
            end
          end else if (cnt >= NOM) begin
            emit     = 1'b1;
            emit_syn = 1'b1;
            cnt_nx   = CNT_W'(1);
            miss_nx  = miss_inc;
            if (miss_inc >= MISS_LIM) begin
              state_nx = ST_ACQUIRE;
              good_nx  = '0;
              miss_nx  = '0;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Stage p2: state, counters and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      good         <= '0;
      miss         <= '0;
      sec_pulse_ed <= 1'b0;
      synth        <= 1'b0;
      locked       <= 1'b0;
      holdover     <= 1'b0;
      period_fix   <= '0;
      err_cnt      <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      good         <= good_nx;
      miss         <= miss_nx;
      sec_pulse_ed <= emit;
      synth        <= emit_syn;
      locked       <= (state_nx == ST_LOCKED);
      holdover     <= (state_nx == ST_HOLDOVER);
      if (fix_ld)  period_fix <= cnt;
      if (err_inc) err_cnt    <= sat_inc_err(err_cnt);
    end
  end

endmodule

// File: doc/pps_conditioner.md
PPS_CONDITIONER -- requirements
Module: pps_conditioner

Interface
REQ-001 SHALL have parameter NOM_PERIOD, default 100000000: nominal clk cycles per second.
REQ-002 SHALL have parameter TOL, default 1000: accept-window half-width in cycles.
REQ-003 SHALL have parameter MISS_MAX, default 3: consecutive synthetic pulses allowed before lock is dropped.
REQ-004 SHALL have ports:
 clk  in  1  sole clock (ADC pclk domain).
 resetn  in  1  reset, asynchronous, active-low.
 pps_in  in  1  raw external PPS, asynchronous, rising-edge active.
 enable  in  1  run control.
 sec_pulse_ed  out  1  one-cycle conditioned second pulse.
 synth  out  1  qualifies sec_pulse_ed as generated, not received.
 locked  out  1  state is LOCKED.
 holdover  out  1  state is HOLDOVER.
 period_fix  out  32  last accepted real interval in cycles.
 err_cnt  out  8  rejected edges, saturating.

Function
REQ-005 SHALL synchronise pps_in through 2 flops and then rising-edge-detect it; a real-edge sec_pulse_ed SHALL appear exactly 3 cycles after the first clk edge that samples pps_in high.
REQ-006 SHALL keep a 32-bit counter cnt; cnt SHALL read 1 in the cycle after an emitted pulse, increment every cycle, and saturate at 2^32-1.
REQ-007 Interval I SHALL be the cnt value in the cycle where the edge is detected; in-window SHALL mean NOM_PERIOD-TOL <= I <= NOM_PERIOD+TOL.
REQ-008 SHALL implement states IDLE, ACQUIRE, LOCKED and HOLDOVER.
REQ-009 IDLE: no pulses; cnt, good count and miss count held at 0; enable=1 moves to ACQUIRE on the next cycle.
REQ-010 ACQUIRE: every edge SHALL be emitted (synth=0); an in-window I increments good count, an out-of-window I clears it; the edge making good count 2 SHALL move to LOCKED.
REQ-011 LOCKED: an in-window edge SHALL be emitted and SHALL set period_fix<=I; an edge with I<NOM_PERIOD-TOL SHALL be suppressed and SHALL increment err_cnt.
REQ-012 LOCKED: if cnt reaches NOM_PERIOD+TOL with no edge that cycle, the block SHALL emit a synthetic pulse (synth=1), set miss count to 1 and move to HOLDOVER; cnt SHALL then equal TOL+1 next cycle, so it tracks time since the ideal instant.
REQ-013 HOLDOVER: at cnt==NOM_PERIOD the block SHALL emit a synthetic pulse and increment miss count; the pulse that makes miss count reach MISS_MAX SHALL still be emitted and SHALL move to ACQUIRE with good count 0.
REQ-014 HOLDOVER: an edge with NOM_PERIOD-TOL <= cnt <= NOM_PERIOD SHALL be emitted as real (synth=0), SHALL clear miss count and SHALL move to LOCKED; period_fix SHALL NOT update. Other edges SHALL be suppressed and counted in err_cnt.
REQ-015 If a real edge and a timeout or synthetic instant fall on the same cycle, the real edge SHALL win and exactly one pulse (synth=0) SHALL be emitted.
REQ-016 enable=0 in any state SHALL force IDLE on the next cycle and zero sec_pulse_ed, synth, locked and holdover; period_fix and err_cnt SHALL hold their values.
REQ-017 err_cnt SHALL saturate at 255; sec_pulse_ed SHALL never be high for 2 consecutive cycles.
REQ-018 locked and holdover SHALL be registered decodes of the state, and SHALL be mutually exclusive.

Reset
REQ-019 resetn=0 SHALL immediately clear the state to IDLE, all outputs, cnt, all counters and the synchroniser flops.
REQ-020 Reset released mid-PPS-high SHALL NOT produce a pulse until a new rising edge arrives.

Structure
REQ-021 The state enum and the counter widths SHALL reside in shared package pps_cond_pkg.
REQ-022 Edge detection SHALL instantiate the existing ed_det sub-module with TYPE "ris".
REQ-023 sec_pulse_ed SHALL connect directly to ref_in_interpretator.sec_pulse_ed.

Verification (NOM_PERIOD=100, TOL=5, MISS_MAX=2)
REQ-024 Edges every 100 cycles -> three pulses, locked=1 after the 3rd edge, period_fix=100, each pulse 3 cycles after its pps_in rise.
REQ-025 LOCKED, edge at I=103 then one at I=50 -> period_fix=103, the I=50 edge gives no pulse and err_cnt=1.
REQ-026 LOCKED, edges stop -> synthetic pulses 105 and 200 cycles after the last edge, holdover=1 after the first, ACQUIRE after the second, then no further pulses.
REQ-027 HOLDOVER, edge at cnt=97 -> pulse with synth=0, locked=1, period_fix unchanged.
REQ-028 LOCKED, edge at I=105 -> single real pulse, stays LOCKED; resetn pulsed low mid-LOCKED -> all outputs 0 at once, IDLE.
